// File: rtl/alu_operand_bypass.sv
// Execute-stage operand select with youngest-first forwarding, load-use stall
// detection, a registered valid/ready output slot and a stall-duration monitor.
module alu_operand_bypass #(
  parameter int DATA_W       = 16,
  parameter int REG_AW       = 3,
  parameter int NUM_OPS      = 2,
  parameter int NUM_SRC      = 3,
  parameter int R0_HARDWIRED = 1,
  parameter int STALL_LIMIT  = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_OPS*2-1:0]      op_sel,
  input  logic [NUM_OPS*REG_AW-1:0] op_raddr,
  input  logic [NUM_OPS*DATA_W-1:0] op_rdata,
  input  logic [DATA_W-1:0]         imm_data,
  input  logic [DATA_W-1:0]         pc_data,
  input  logic [NUM_SRC-1:0]        fwd_valid,
  input  logic [NUM_SRC-1:0]        fwd_pending,
  input  logic [NUM_SRC*REG_AW-1:0] fwd_waddr,
  input  logic [NUM_SRC*DATA_W-1:0] fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_OPS*DATA_W-1:0] out_data,
  output logic [NUM_OPS-1:0]        out_fwd,
  output logic                      stall,
  output logic [7:0]                stall_cnt,
  output logic                      err_timeout
);

  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_IMM = 2'd1;
  localparam logic [1:0] SEL_PC  = 2'd2;

  typedef enum logic {S_RUN = 1'b0, S_STALL = 1'b1} state_t;

  logic [NUM_OPS*DATA_W-1:0] w_opnd;
  logic [NUM_OPS-1:0]        w_fwd;
  logic                      w_hazard;
  logic                      w_accept;
  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [7:0]                r_cnt;
  logic [7:0]                w_cnt_nxt;
  logic                      r_out_valid;
  logic [NUM_OPS*DATA_W-1:0] r_out_data;
  logic [NUM_OPS-1:0]        r_out_fwd;
  logic                      r_err;

  // Stage p0: per-operand base select, then the first (youngest) matching
  // source decides; a pending match blocks older sources from being used.
  always_comb begin : operand_select
    logic [1:0]        w_sel;
    logic [REG_AW-1:0] w_ra;
    logic              w_found;
    logic              w_haz_any;
    w_opnd    = '0;
    w_fwd     = '0;
    w_haz_any = 1'b0;
    w_sel     = '0;
    w_ra      = '0;
    w_found   = 1'b0;
    for (int k = 0; k < NUM_OPS; k++) begin
      w_sel   = op_sel[k*2 +: 2];
      w_ra    = op_raddr[k*REG_AW +: REG_AW];
      w_found = 1'b0;
      case (w_sel)
        SEL_REG: w_opnd[k*DATA_W +: DATA_W] = op_rdata[k*DATA_W +: DATA_W];
        SEL_IMM: w_opnd[k*DATA_W +: DATA_W] = imm_data;
        SEL_PC:  w_opnd[k*DATA_W +: DATA_W] = pc_data;
        default: w_opnd[k*DATA_W +: DATA_W] = '0;
      endcase
      if (w_sel == SEL_REG && !(R0_HARDWIRED != 0 && w_ra == '0)) begin
        for (int s = 0; s < NUM_SRC; s++) begin
          if (!w_found && fwd_valid[s] && fwd_waddr[s*REG_AW +: REG_AW] == w_ra) begin
            w_found = 1'b1;
            if (fwd_pending[s]) begin
              w_haz_any = 1'b1;
            end else begin
              w_opnd[k*DATA_W +: DATA_W] = fwd_data[s*DATA_W +: DATA_W];
              w_fwd[k] = 1'b1;
            end
          end
        end
      end
    end
    w_hazard = in_valid && w_haz_any;
  end

  assign in_ready = !flush && !w_hazard && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Stage p1: output slot; flush kills valid but leaves the data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_fwd   <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_opnd;
      r_out_fwd   <= w_fwd;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_RUN: begin
        w_cnt_nxt = '0;
        if (w_hazard && !flush) begin
          w_state_nxt = S_STALL;
          w_cnt_nxt   = 8'd1;
        end
      end
      S_STALL: begin
        if (flush || !w_hazard) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else if (r_cnt != 8'hFF) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The counter shows the number of the stall cycle in progress, so the
  // timeout flag rises in the same cycle the count reaches the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_state_nxt == S_STALL && w_cnt_nxt == 8'(STALL_LIMIT))
        r_err <= 1'b1;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_fwd     = r_out_fwd;
  assign stall       = (r_state == S_STALL);
  assign stall_cnt   = r_cnt;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_alu_operand_bypass.sv
// Bench for alu_operand_bypass: directed vector table, hand-written stall,
// backpressure and flush sequences, then random traffic against a reference model.
module tb_alu_operand_bypass;

  localparam int LIMIT = 15;
  localparam logic [1:0] REG = 2'd0, IMM = 2'd1, PC = 2'd2, ZERO = 2'd3;

  typedef struct packed {
    logic [3:0]  sel;
    logic [5:0]  ra;
    logic [31:0] rd;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [2:0]  fv;
    logic [2:0]  fp;
    logic [8:0]  fa;
    logic [47:0] fd;
  } req_t;

  typedef struct packed {
    req_t        rq;
    logic [31:0] d;
    logic [1:0]  f;
    logic        rdy;
  } vec_t;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op_sel;
  logic [5:0]  op_raddr;
  logic [31:0] op_rdata, out_data;
  logic [15:0] imm_data, pc_data;
  logic [2:0]  fwd_valid, fwd_pending;
  logic [8:0]  fwd_waddr;
  logic [47:0] fwd_data;
  logic [1:0]  out_fwd;
  logic        stall, err_timeout;
  logic [7:0]  stall_cnt;

  int   n_pass = 0;
  int   n_tot  = 0;
  req_t cur;
  vec_t vq[$];

  alu_operand_bypass #(.DATA_W(16), .REG_AW(3), .NUM_OPS(2), .NUM_SRC(3),
                       .R0_HARDWIRED(1), .STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .op_raddr(op_raddr), .op_rdata(op_rdata), .imm_data(imm_data),
    .pc_data(pc_data), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
    .fwd_waddr(fwd_waddr), .fwd_data(fwd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_fwd(out_fwd), .stall(stall),
    .stall_cnt(stall_cnt), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input req_t r);
    op_sel = r.sel; op_raddr = r.ra; op_rdata = r.rd; imm_data = r.imm; pc_data = r.pc;
    fwd_valid = r.fv; fwd_pending = r.fp; fwd_waddr = r.fa; fwd_data = r.fd;
  endtask

  task automatic clr();
    cur = '0;
  endtask

  task automatic set_op(input int k, input logic [1:0] s, input logic [2:0] a,
                        input logic [15:0] d);
    cur.sel[k*2 +: 2] = s;
    cur.ra[k*3 +: 3]  = a;
    cur.rd[k*16 +: 16] = d;
  endtask

  task automatic set_src(input int s, input logic v, input logic p,
                         input logic [2:0] a, input logic [15:0] d);
    cur.fv[s] = v;
    cur.fp[s] = p;
    cur.fa[s*3 +: 3] = a;
    cur.fd[s*16 +: 16] = d;
  endtask

  task automatic add_vec(input logic [31:0] d, input logic [1:0] f, input logic rdy);
    vec_t v;
    v.rq = cur; v.d = d; v.f = f; v.rdy = rdy;
    vq.push_back(v);
  endtask

  // Reference: list every source writing the operand's register, youngest
  // first; the head of that list alone decides forward vs. hazard.
  function automatic void model(input req_t r, output logic [31:0] d,
                                output logic [1:0] f, output logic h);
    logic [1:0]  s;
    logic [2:0]  a;
    logic [15:0] v;
    int          hits[$];
    d = '0; f = '0; h = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s = r.sel[k*2 +: 2];
      a = r.ra[k*3 +: 3];
      hits.delete();
      case (s)
        REG:     v = r.rd[k*16 +: 16];
        IMM:     v = r.imm;
        PC:      v = r.pc;
        default: v = 16'h0;
      endcase
      if (s == REG && a != 3'd0)
        for (int j = 0; j < 3; j++)
          if (r.fv[j] && r.fa[j*3 +: 3] == a) hits.push_back(j);
      if (hits.size() > 0) begin
        if (r.fp[hits[0]]) h = 1'b1;
        else begin
          v = r.fd[hits[0]*16 +: 16];
          f[k] = 1'b1;
        end
      end
      d[k*16 +: 16] = v;
    end
  endfunction

  initial begin
    logic [31:0] md, e_data;
    logic [1:0]  mf, e_fwd;
    logic        mh, hz, iv, ordy, fl, erdy, e_vld, e_stall, e_err;
    int          e_cnt;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    clr(); drive(cur);
    tick(); tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_fwd", out_fwd, 0);
    chk("rst_stall", stall, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    tick();

    // Directed vector table
    clr(); set_op(0, REG, 3, 16'h5555); set_op(1, IMM, 0, 16'h9999); cur.imm = 16'h00AB;
    set_src(1, 1, 0, 3, 16'h1234); add_vec(32'h00AB_1234, 2'b01, 1);
    clr(); set_op(0, REG, 5, 16'h5A5A); set_op(1, ZERO, 0, 16'hFFFF);
    set_src(0, 1, 0, 5, 16'h1111); set_src(2, 1, 0, 5, 16'h2222); add_vec(32'h0000_1111, 2'b01, 1);
    clr(); set_op(0, PC, 0, 16'h0001); set_op(1, REG, 6, 16'h6666); cur.pc = 16'h4000;
    set_src(0, 1, 0, 5, 16'hAAAA); add_vec(32'h6666_4000, 2'b00, 1);
    clr(); set_op(0, REG, 0, 16'h0A0A); set_op(1, IMM, 0, 16'h0); cur.imm = 16'h0001;
    set_src(0, 1, 1, 0, 16'hDEAD); add_vec(32'h0001_0A0A, 2'b00, 1);
    clr(); set_op(0, ZERO, 0, 16'h1234); set_op(1, REG, 4, 16'h4444);
    set_src(1, 0, 0, 4, 16'hDEAD); set_src(2, 1, 0, 4, 16'hBEEF); add_vec(32'hBEEF_0000, 2'b10, 1);
    clr(); set_op(0, REG, 2, 16'h0); set_src(0, 1, 1, 2, 16'h0); add_vec(32'h0, 2'b00, 0);
    clr(); set_op(1, REG, 7, 16'h7070); set_src(0, 1, 1, 7, 16'h0);
    set_src(1, 1, 0, 7, 16'h1717); add_vec(32'h0, 2'b00, 0);
    clr(); set_op(0, IMM, 3, 16'h0); cur.imm = 16'h7777; set_op(1, ZERO, 0, 16'h0);
    set_src(0, 1, 1, 3, 16'h0); add_vec(32'h0000_7777, 2'b00, 1);
    clr(); set_op(0, REG, 1, 16'h0101); set_op(1, REG, 2, 16'h0202);
    set_src(0, 1, 0, 2, 16'hBBBB); set_src(1, 1, 0, 1, 16'hAAAA); add_vec(32'hBBBB_AAAA, 2'b11, 1);
    clr(); set_op(0, REG, 6, 16'h0606); set_op(1, ZERO, 0, 16'h0);
    set_src(0, 1, 0, 6, 16'h6060); set_src(1, 1, 1, 6, 16'h0); add_vec(32'h0000_6060, 2'b01, 1);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rq); in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vq[i].rdy);
      tick();
      if (vq[i].rdy) begin
        chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
        chk($sformatf("vec%0d_out_data", i), out_data, vq[i].d);
        chk($sformatf("vec%0d_out_fwd", i), out_fwd, vq[i].f);
      end
      in_valid = 1'b0;
      tick();
    end

    // Load-use stall resolving after four hazard cycles
    clr(); set_op(0, REG, 2, 16'h2222); set_op(1, ZERO, 0, 16'h0); set_src(0, 1, 1, 2, 16'h0);
    drive(cur); in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lu_in_ready", in_ready, 0);
      chk("lu_stall", stall, (i > 0));
      chk("lu_stall_cnt", stall_cnt, i);
      tick();
    end
    set_src(0, 1, 0, 2, 16'h0F0F); drive(cur);
    @(negedge clk);
    chk("lu_release_stall", stall, 1);
    chk("lu_release_cnt", stall_cnt, 4);
    chk("lu_release_ready", in_ready, 1);
    tick();
    chk("lu_out_valid", out_valid, 1);
    chk("lu_out_data", out_data, 32'h0000_0F0F);
    chk("lu_out_fwd", out_fwd, 2'b01);
    chk("lu_stall_after", stall, 0);
    chk("lu_cnt_after", stall_cnt, 0);
    in_valid = 1'b0;
    tick();

    // Backpressure: held slot stays stable, then back-to-back accepts
    clr(); set_op(0, IMM, 0, 16'h0); set_op(1, ZERO, 0, 16'h0); cur.imm = 16'h1111;
    drive(cur); in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("bp_first_ready", in_ready, 1);
    tick();
    cur.imm = 16'h2222; drive(cur);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_blocked_ready", in_ready, 0);
      chk("bp_held_valid", out_valid, 1);
      chk("bp_held_data", out_data, 32'h0000_1111);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_ready", in_ready, 1);
    tick();
    chk("bp_second_data", out_data, 32'h0000_2222);
    cur.imm = 16'h3333; drive(cur);
    @(negedge clk);
    chk("bp_b2b_ready", in_ready, 1);
    tick();
    chk("bp_third_valid", out_valid, 1);
    chk("bp_third_data", out_data, 32'h0000_3333);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", out_valid, 0);

    // Flush during a stall with a held output slot
    clr(); set_op(0, IMM, 0, 16'h0); set_op(1, ZERO, 0, 16'h0); cur.imm = 16'h4444;
    drive(cur); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    clr(); set_op(0, REG, 4, 16'h0); set_op(1, ZERO, 0, 16'h0); set_src(2, 1, 1, 4, 16'h0);
    drive(cur);
    tick(); tick();
    chk("fl_pre_stall", stall, 1);
    chk("fl_pre_valid", out_valid, 1);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_in_ready", in_ready, 0);
    tick();
    chk("fl_stall", stall, 0);
    chk("fl_cnt", stall_cnt, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_data_kept", out_data, 32'h0000_4444);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // Long stall: timeout flag and its stickiness
    clr(); set_op(0, REG, 5, 16'h0); set_op(1, ZERO, 0, 16'h0); set_src(1, 1, 1, 5, 16'h0);
    drive(cur); in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("to_stall", stall, (i > 0));
      chk("to_cnt", stall_cnt, i);
      chk("to_err", err_timeout, (i >= LIMIT));
      tick();
    end
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("to_stall_end", stall, 0);
    chk("to_cnt_end", stall_cnt, 0);
    chk("to_err_sticky", err_timeout, 1);

    // Asynchronous reset in the middle of a stall
    in_valid = 1'b1;
    tick(); tick(); tick();
    chk("mr_pre_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_stall", stall, 0);
    chk("mr_cnt", stall_cnt, 0);
    chk("mr_err", err_timeout, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_data", out_data, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Random traffic against the reference model
    e_vld = 1'b0; e_data = '0; e_fwd = '0; e_stall = 1'b0; e_cnt = 0; e_err = 1'b0;
    for (int n = 0; n < 400; n++) begin
      clr();
      for (int k = 0; k < 2; k++)
        set_op(k, ($urandom_range(0, 1) != 0) ? REG : 2'($urandom_range(0, 3)),
               3'($urandom_range(0, 7)), 16'($urandom));
      for (int s = 0; s < 3; s++)
        set_src(s, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                3'($urandom_range(0, 7)), 16'($urandom));
      cur.imm = 16'($urandom); cur.pc = 16'($urandom);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      drive(cur); in_valid = iv; out_ready = ordy; flush = fl;
      model(cur, md, mf, mh);
      hz   = iv && mh;
      erdy = !fl && !hz && (!e_vld || ordy);
      @(negedge clk);
      chk("rnd_in_ready", in_ready, erdy);
      if (fl) e_vld = 1'b0;
      else if (iv && erdy) begin
        e_vld = 1'b1; e_data = md; e_fwd = mf;
      end else if (ordy) e_vld = 1'b0;
      e_stall = hz && !fl;
      e_cnt   = e_stall ? ((e_cnt >= 255) ? 255 : e_cnt + 1) : 0;
      if (e_cnt == LIMIT) e_err = 1'b1;
      tick();
      chk("rnd_out_valid", out_valid, e_vld);
      chk("rnd_stall", stall, e_stall);
      chk("rnd_stall_cnt", stall_cnt, e_cnt);
      chk("rnd_err", err_timeout, e_err);
      if (e_vld) begin
        chk("rnd_out_data", out_data, e_data);
        chk("rnd_out_fwd", out_fwd, e_fwd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
